// File: rtl/mimo_lane_serializer_if.sv
// Handshake bundle for the lane serializer: parallel word in, one lane per beat out.
interface mimo_lane_serializer_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [LW-1:0]           out_lane;
  logic                    out_last;
  logic [FW-1:0]           fill_level;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, fill_level
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, fill_level
  );
endinterface

// File: rtl/mimo_lane_serializer.sv
// Buffers N-lane parallel words in a small FIFO and streams them out one lane per beat,
// lane 0 first, popping the head word after its last lane.
module mimo_lane_serializer #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mimo_lane_serializer_if.slave   bus
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {EMPTY, STREAM} state_t;
  state_t state, state_nxt;

  logic [N-1:0][DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] count;
  logic [LW-1:0] lane;
  logic          streaming, push, beat, pop, lane_end;

  // in_ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready   = !rst && (count < FW'(FIFO_DEPTH));
  assign push           = bus.in_valid && bus.in_ready;
  assign streaming      = (state == STREAM);
  assign lane_end       = (lane == LW'(N-1));
  assign beat           = streaming && bus.out_ready;
  assign pop            = beat && lane_end;

  assign bus.out_valid  = streaming;
  assign bus.out_data   = mem[rd_ptr][lane];
  assign bus.out_lane   = lane;
  assign bus.out_last   = streaming && lane_end;
  assign bus.fill_level = count;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:  if (push) state_nxt = STREAM;
      STREAM: if (pop && !push && count == FW'(1)) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      lane   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (beat) lane   <= lane_end ? '0 : lane + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end
endmodule

// File: tb/tb_mimo_lane_serializer.sv
// Directed bench for mimo_lane_serializer: hand-built words, expected beats queued per lane.
module tb_mimo_lane_serializer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int FD = 4;

  typedef logic [N-1:0][DW-1:0] word_t;
  typedef struct {logic [DW-1:0] d; int lane;} beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mimo_lane_serializer_if #(.N(N), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus();
  mimo_lane_serializer #(.N(N), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_t w [21];
  beat_t exp_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i);
    for (int k = 0; k < N; k++) exp_q.push_back('{w[i][k], k});
  endtask

  task automatic check_beat(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_extra_beat"}, bus.out_valid, 0);
    end else begin
      chk({tag, "_data"}, bus.out_data, exp_q[0].d);
      chk({tag, "_lane"}, bus.out_lane, exp_q[0].lane);
      chk({tag, "_last"}, bus.out_last, exp_q[0].lane == N-1);
    end
  endtask

  // Push words first..last whenever in_ready, drain everything, check every beat in order.
  task automatic stream(input int first, input int last, input bit stall,
                        input bit gapless, input bit chk_first_pop);
    int idx = first;
    int stalls = 0;
    bit started = 0, popped = 0, hs, pop_now, done = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = (idx <= last);
    if (idx <= last) bus.data_in = w[idx];
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (bus.out_valid) begin
        started = 1;
        check_beat("stream");
      end else if (gapless && started && exp_q.size() > 0) begin
        chk("stream_gap", bus.out_valid, 1);
      end
      bus.out_ready = !(stall && bus.out_valid && stalls < 3 && exp_q.size() > 0 &&
                        exp_q[0].d == 16'h0B0B && exp_q[0].lane == 2);
      if (!bus.out_ready) stalls++;
      hs      = bus.out_valid && bus.out_ready;
      pop_now = hs && (bus.out_lane == N-1);
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        push_exp(idx);
        idx++;
      end
      step;
      if (chk_first_pop && pop_now && !popped) begin
        popped = 1;
        chk("in_ready_after_first_pop", bus.in_ready, 1);
      end
      bus.in_valid = (idx <= last);
      if (idx <= last) bus.data_in = w[idx];
      done = (idx > last) && (exp_q.size() == 0) && !bus.out_valid;
    end
    chk("stream_done", done, 1);
    if (stall) chk("stall_cycles", stalls, 3);
    chk("stream_end_fill", bus.fill_level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    w[0] = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
    w[1] = {16'h0010, 16'h0020, 16'h0030, 16'h0040};
    w[2] = {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    for (int i = 3; i < 21; i++)
      for (int k = 0; k < N; k++) w[i][k] = 16'(i*256 + k*16 + 5);

    // reset
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.data_in = '0;
    step; step;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_fill", bus.fill_level, 0);
    chk("rst_lane", bus.out_lane, 0);
    chk("rst_last", bus.out_last, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // single word, latency 1, lanes on consecutive cycles
    bus.in_valid = 1'b1; bus.data_in = w[0]; bus.out_ready = 1'b1;
    step;
    bus.in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_data", bus.out_data, w[0][k]);
      chk("t1_lane", bus.out_lane, k);
      chk("t1_last", bus.out_last, k == N-1);
      chk("t1_fill", bus.fill_level, 1);
      step;
    end
    chk("t1_end_valid", bus.out_valid, 0);
    chk("t1_end_fill", bus.fill_level, 0);

    // fill to capacity with sink stalled, 5th word held off
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.data_in = w[i];
      chk("t2_in_ready", bus.in_ready, 1);
      push_exp(i);
      step;
      chk("t2_fill", bus.fill_level, i);
    end
    bus.data_in = w[5];
    chk("t2_full_in_ready", bus.in_ready, 0);
    step; step;
    chk("t2_full_fill", bus.fill_level, FD);
    chk("t2_full_in_ready_held", bus.in_ready, 0);
    chk("t2_head_data", bus.out_data, 16'h0040);
    // release, with a 3-cycle stall on 0B0B lane 2
    stream(5, 5, 1'b1, 1'b0, 1'b1);

    // push and pop in the same cycle at fill_level 1
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.data_in = w[6];
    step;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step; step; step;
    chk("t3_lane3", bus.out_lane, 3);
    chk("t3_fill_before", bus.fill_level, 1);
    bus.in_valid = 1'b1; bus.data_in = w[7];
    step;
    bus.in_valid = 1'b0;
    chk("t3_fill_same", bus.fill_level, 1);
    chk("t3_lane0", bus.out_lane, 0);
    chk("t3_data", bus.out_data, w[7][0]);
    chk("t3_valid", bus.out_valid, 1);
    step; step; step; step;
    chk("t3_drain_fill", bus.fill_level, 0);
    chk("t3_drain_valid", bus.out_valid, 0);

    // reset mid-word with 3 words buffered
    bus.out_ready = 1'b0;
    for (int i = 8; i <= 10; i++) begin
      bus.in_valid = 1'b1; bus.data_in = w[i];
      step;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step;
    chk("t4_lane1", bus.out_lane, 1);
    chk("t4_fill3", bus.fill_level, 3);
    rst = 1'b1;
    #1;
    chk("t4_rst_in_ready", bus.in_ready, 0);
    step;
    rst = 1'b0;
    #1;
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_fill", bus.fill_level, 0);
    chk("t4_lane", bus.out_lane, 0);
    chk("t4_last", bus.out_last, 0);
    chk("t4_in_ready", bus.in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      step;
      chk("t4_no_stale", bus.out_valid, 0);
    end

    // 10 words back to back: gap-free, pointers wrap twice
    stream(11, 20, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
